// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// One result bit per CALC cycle; sign correction applied in a single FIX cycle.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_sa, r_sb, r_busy, r_done;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_signed, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
    logic [WIDTH:0]     w_sum, w_trial;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;

    assign w_signed = ~op[0];
    assign w_neg_a  = w_signed & A[WIDTH-1];
    assign w_neg_b  = w_signed & B[WIDTH-1];
    assign w_mag_a  = w_neg_a ? (~A + 1'b1) : A;
    assign w_mag_b  = w_neg_b ? (~B + 1'b1) : B;

    // Multiply: accumulator is {partial product, remaining multiplier bits}
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: accumulator is {remainder, dividend bits shifting into quotient}
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // A zero divisor leaves quotient all-ones and remainder = |A|; re-signing |A| restores A
    assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = ((r_sa ^ r_sb) && (r_b != '0)) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_sa ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_acc   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !op[2]) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_div   <= op[1];
                        r_sa    <= w_neg_a;
                        r_sb    <= w_neg_b;
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                    end else if (start && !op[1]) begin
                        if (op[0]) r_lo <= A;
                        else       r_hi <= A;
                    end
                end
                CALC: begin
                    // count 0 seeds the accumulator, counts 1..WIDTH each retire one bit
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= (r_cnt == '0) ? (r_div ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{1'b0}}, r_b})
                                           : (r_div ? w_div_next : w_mul_next);
                    if (r_cnt == CW'(WIDTH)) r_state <= FIX;
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_hi    <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= r_div ? w_quo : w_prod[WIDTH-1:0];
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter; reference results from plain 64-bit arithmetic.
module tb_mdu_iter;
    logic        clk = 0, rst = 1, start = 0;
    logic [2:0]  op = '0;
    logic [31:0] A = '0, B = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0, vecs = 0, errs = 0;
    int          m_n0 = -100, m_dlast = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    bit          run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: MIPS results from integer arithmetic, returned as {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        int ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ia = a;
        ib = b;
        if (o == 3'd0) return sa * sb;
        if (o == 3'd1) return 64'(a) * 64'(b);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        @(negedge clk);
        start = 1; op = o; A = a; B = b;
        if (cyc >= m_dlast) begin
            if (!o[2]) begin
                r = model(o, a, b);
                q.push_back('{r[63:32], r[31:0], cyc + 35});
                m_n0 = cyc;
                m_dlast = cyc + 35;
            end else if (!o[1]) begin
                if (o[0]) m_lo = a;
                else      m_hi = a;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 0;
        end
    endtask

    // Monitor: pops the scoreboard on done, checks busy window and HI/LO hold while busy
    always @(negedge clk) begin
        exp_t e;
        if (run && !rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected_done at cyc %0d: got done=1 expected done=0", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                vecs++; errs++;
                $display("FAIL missing_done at cyc %0d: got done=0 expected done=1 at cyc %0d", cyc, e.cyc);
            end
            chk("busy", {31'b0, busy}, {31'b0, (cyc > m_n0) && (cyc < m_dlast)});
            if (busy) begin
                chk("hi_hold", hi, m_hi);
                chk("lo_hold", lo, m_lo);
            end
        end
    end

    function automatic logic [31:0] rnd_val();
        int s = $urandom_range(0, 9);
        logic [31:0] v = $urandom;
        return s == 0 ? 32'h0 : s == 1 ? 32'h8000_0000 : s == 2 ? 32'hFFFF_FFFF :
               s == 3 ? 32'h1 : s == 4 ? (v & 32'hFF) : v;
    endfunction

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        run = 1;

        issue(3'd0, 32'hFFFF_FFFF, 32'h2);           idle(40);
        issue(3'd1, 32'hFFFF_FFFF, 32'h2);           idle(40);
        issue(3'd3, 32'd100, 32'd7);                 idle(40);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);           idle(40);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);   idle(40);
        issue(3'd2, 32'h0000_002A, 32'h0);           idle(40);
        issue(3'd3, 32'h0000_002A, 32'h0);           idle(40);
        issue(3'd2, 32'hFFFF_FFD6, 32'h0);           idle(40);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000);   idle(40);

        issue(3'd1, 32'd3, 32'd5); idle(9);
        issue(3'd0, 32'd9, 32'd9); idle(1);
        while (cyc < m_dlast - 1) idle(1);
        issue(3'd2, 32'hFFFF_FF9C, 32'd7); idle(40);

        issue(3'd4, 32'h1234_5678, 32'h0);
        idle(1);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'b0, busy}, 32'h0);
        issue(3'd5, 32'h9ABC_DEF0, 32'h0);
        idle(1);
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mtlo_done", {31'b0, done}, 32'h0);
        issue(3'd6, 32'hDEAD_BEEF, 32'h1); idle(1);
        issue(3'd7, 32'hDEAD_BEEF, 32'h1); idle(3);
        chk("noop_hi", hi, 32'h1234_5678);
        chk("noop_lo", lo, 32'h9ABC_DEF0);

        issue(3'd3, 32'hFFFF_0000, 32'd13); idle(18);
        @(negedge clk);
        rst = 1; run = 0;
        q.delete();
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        rst = 0;
        m_hi = '0; m_lo = '0; m_dlast = 0; m_n0 = -100;
        run = 1;
        idle(45);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
            else idle(1);
        end
        idle(1);
        t = 0;
        while (q.size() != 0 && t < 100) begin
            idle(1);
            t++;
        end
        if (q.size() != 0) begin
            vecs++; errs++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
